// File: rtl/ads_spi_seq_ctrl.sv
// SPI master sequencer for ADS868x-style multichannel SAR ADCs (single-shot and round-robin continuous).
// Latency: a result appears one frame after its command; data_valid pulses in the first csn-high cycle.
// Backpressure: none; data_valid is a one-cycle strobe, start is ignored while busy.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   start/mode          begin operation (sampled in IDLE only); 0 = single-shot, 1 = continuous
//   ch_sel/ch_mask      single-shot channel / continuous enable mask, both latched at start
//   run                 continuous keep-going level, sampled at the end of every inter-frame gap
//   busy                high from start acceptance until the final frame's gap completes
//   data_o/ch_o         captured result and its channel tag, valid while data_valid is high
//   err                 one-cycle strobe when a continuous start has an empty mask
//   csn/sclk/sdi/sdo    ADC SPI pins (sclk idles low, sdo sampled on sclk rising)
module ads_spi_seq_ctrl #(
    parameter int          NUM_CH     = 4,
    parameter int          DATA_WIDTH = 16,
    parameter int          FRAME_BITS = 32,
    parameter int          SCLK_DIV   = 2,
    parameter int          CS_GAP     = 4,
    parameter logic [15:0] CMD_BASE   = 16'hC000,
    parameter int          CH_SHIFT   = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      mode,
    input  logic [$clog2(NUM_CH)-1:0] ch_sel,
    input  logic [NUM_CH-1:0]         ch_mask,
    input  logic                      run,
    output logic                      busy,
    output logic [DATA_WIDTH-1:0]     data_o,
    output logic [$clog2(NUM_CH)-1:0] ch_o,
    output logic                      data_valid,
    output logic                      err,
    output logic                      csn,
    output logic                      sclk,
    output logic                      sdi,
    input  logic                      sdo
);

    localparam int CH_W    = $clog2(NUM_CH);
    localparam int CNT_MAX = (SCLK_DIV > CS_GAP) ? SCLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(FRAME_BITS + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cyc_q, cyc_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic                    half_q, half_d;        // 0 = sclk low half, 1 = high half
    logic [FRAME_BITS-1:0]   tx_q, tx_d;
    logic [DATA_WIDTH-1:0]   rx_q, rx_d;
    logic                    mode_q, mode_d;
    logic [NUM_CH-1:0]       mask_q, mask_d;
    logic [CH_W-1:0]         cmd_ch_q, cmd_ch_d;    // channel commanded in the current frame
    logic [CH_W-1:0]         res_ch_q, res_ch_d;    // channel whose result the current frame returns
    logic                    has_res_q, has_res_d;
    logic                    last_q, last_d;        // current frame is the final one of the operation
    logic                    busy_q, busy_d;
    logic                    data_valid_q, data_valid_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   data_o_q, data_o_d;
    logic [CH_W-1:0]         ch_o_q, ch_o_d;
    logic                    csn_q, csn_d;
    logic                    sclk_q, sclk_d;
    logic                    sdi_q, sdi_d;
    logic                    half_done;

    function automatic logic [CH_W-1:0] first_ch(input logic [NUM_CH-1:0] m);
        logic [CH_W-1:0] f;
        f = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) f = CH_W'(i);
        end
        return f;
    endfunction

    // Next enabled channel above cur, wrapping to the lowest enabled one.
    function automatic logic [CH_W-1:0] next_ch(input logic [NUM_CH-1:0] m, input logic [CH_W-1:0] cur);
        logic [CH_W-1:0] n;
        logic            found;
        n     = first_ch(m);
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && m[i] && (i > int'(cur))) begin
                n     = CH_W'(i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic logic [FRAME_BITS-1:0] cmd_word(input logic [CH_W-1:0] ch);
        logic [15:0] c;
        c = CMD_BASE | (16'(ch) << CH_SHIFT);
        return FRAME_BITS'(c) << (FRAME_BITS - 16);
    endfunction

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        bit_d        = bit_q;
        half_d       = half_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        mode_d       = mode_q;
        mask_d       = mask_q;
        cmd_ch_d     = cmd_ch_q;
        res_ch_d     = res_ch_q;
        has_res_d    = has_res_q;
        last_d       = last_q;
        busy_d       = busy_q;
        data_valid_d = 1'b0;
        err_d        = 1'b0;
        data_o_d     = data_o_q;
        ch_o_d       = ch_o_q;
        half_done    = (cyc_q == CNT_W'(SCLK_DIV - 1));

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (mode && (ch_mask == '0)) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d    = mode;
                        mask_d    = ch_mask;
                        cmd_ch_d  = mode ? first_ch(ch_mask) : ch_sel;
                        tx_d      = cmd_word(cmd_ch_d);
                        has_res_d = 1'b0;
                        last_d    = 1'b0;
                        busy_d    = 1'b1;
                        cyc_d     = '0;
                        state_d   = SETUP;
                    end
                end
            end
            SETUP: begin
                cyc_d = cyc_q + CNT_W'(1);
                if (half_done) begin
                    cyc_d   = '0;
                    half_d  = 1'b0;
                    bit_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                cyc_d = cyc_q + CNT_W'(1);
                if (half_done) begin
                    cyc_d = '0;
                    if (!half_q) begin
                        // End of low half: sclk rises next, so sample sdo now.
                        half_d = 1'b1;
                        if (bit_q < BIT_W'(DATA_WIDTH)) rx_d = {rx_q[DATA_WIDTH-2:0], sdo};
                    end else if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
                        half_d  = 1'b0;
                        state_d = HOLD;
                    end else begin
                        // sdi advances only as a new low half begins.
                        half_d = 1'b0;
                        bit_d  = bit_q + BIT_W'(1);
                        tx_d   = tx_q << 1;
                    end
                end
            end
            HOLD: begin
                cyc_d = cyc_q + CNT_W'(1);
                if (half_done) begin
                    cyc_d   = '0;
                    state_d = GAP;
                    if (has_res_q) begin
                        data_valid_d = 1'b1;
                        data_o_d     = rx_q;
                        ch_o_d       = res_ch_q;
                    end
                end
            end
            GAP: begin
                cyc_d = cyc_q + CNT_W'(1);
                if (cyc_q == CNT_W'(CS_GAP - 1)) begin
                    cyc_d = '0;
                    if (last_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d   = SETUP;
                        has_res_d = 1'b1;
                        res_ch_d  = cmd_ch_q;
                        if (mode_q && run) begin
                            cmd_ch_d = next_ch(mask_q, cmd_ch_q);
                            tx_d     = cmd_word(cmd_ch_d);
                        end else begin
                            // NO_OP frame flushes out the last pending result.
                            last_d = 1'b1;
                            tx_d   = '0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Pins are registered from the next-state view so they come straight off flops.
        csn_d  = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
        sclk_d = (state_d == SHIFT) && half_d;
        sdi_d  = ((state_d == SETUP) || (state_d == SHIFT)) ? tx_d[FRAME_BITS-1] : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cyc_q        <= '0;
            bit_q        <= '0;
            half_q       <= 1'b0;
            tx_q         <= '0;
            rx_q         <= '0;
            mode_q       <= 1'b0;
            mask_q       <= '0;
            cmd_ch_q     <= '0;
            res_ch_q     <= '0;
            has_res_q    <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            data_valid_q <= 1'b0;
            err_q        <= 1'b0;
            data_o_q     <= '0;
            ch_o_q       <= '0;
            csn_q        <= 1'b1;
            sclk_q       <= 1'b0;
            sdi_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            bit_q        <= bit_d;
            half_q       <= half_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            mode_q       <= mode_d;
            mask_q       <= mask_d;
            cmd_ch_q     <= cmd_ch_d;
            res_ch_q     <= res_ch_d;
            has_res_q    <= has_res_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            data_valid_q <= data_valid_d;
            err_q        <= err_d;
            data_o_q     <= data_o_d;
            ch_o_q       <= ch_o_d;
            csn_q        <= csn_d;
            sclk_q       <= sclk_d;
            sdi_q        <= sdi_d;
        end
    end

    assign busy       = busy_q;
    assign data_o     = data_o_q;
    assign ch_o       = ch_o_q;
    assign data_valid = data_valid_q;
    assign err        = err_q;
    assign csn        = csn_q;
    assign sclk       = sclk_q;
    assign sdi        = sdi_q;

endmodule

// File: tb/tb_ads_spi_seq_ctrl.sv
// Bench for ads_spi_seq_ctrl: behavioural ADC on the SPI pins, scoreboard queues of expected
// command words and tagged results, and a negedge monitor checking frame timing and outputs.
module tb_ads_spi_seq_ctrl;
    localparam int NUM_CH = 4;
    localparam int FB     = 32;
    localparam int DIV    = 2;
    localparam int GAPC   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, mode, run;
    logic [1:0]  ch_sel;
    logic [3:0]  ch_mask;
    logic        busy, data_valid, err, csn, sclk, sdi, sdo;
    logic [15:0] data_o;
    logic [1:0]  ch_o;

    ads_spi_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .ch_sel(ch_sel), .ch_mask(ch_mask),
        .run(run), .busy(busy), .data_o(data_o), .ch_o(ch_o), .data_valid(data_valid),
        .err(err), .csn(csn), .sclk(sclk), .sdi(sdi), .sdo(sdo)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural ADC: returns the previous frame's selected channel ----------------
    logic [15:0] ain [NUM_CH];
    logic [15:0] adc_out;
    logic [31:0] adc_in;
    int          adc_bits;
    logic [1:0]  adc_sel;

    initial begin
        sdo = 1'b0; adc_sel = 2'd0; adc_bits = 0; adc_out = '0; adc_in = '0;
    end
    always @(negedge csn) begin
        adc_out  = ain[adc_sel];
        sdo      = adc_out[15];
        adc_bits = 0;
    end
    always @(negedge sclk) if (!csn) begin
        adc_out = adc_out << 1;
        sdo     = adc_out[15];
    end
    always @(posedge sclk) if (!csn) begin
        adc_in = {adc_in[30:0], sdi};
        adc_bits++;
    end
    always @(posedge csn) begin
        if (adc_bits == FB && adc_in[31:29] == 3'b110) adc_sel = adc_in[27:26];
    end

    // ---------------- scoreboard ----------------
    typedef struct {logic [1:0] ch; logic [15:0] dat;} res_t;
    res_t        exp_res[$];
    logic [31:0] exp_cmd[$];

    function automatic logic [31:0] cmd_of(input logic [1:0] ch);
        return 32'hC000_0000 | (32'(ch) << 26);
    endfunction

    // ---------------- monitor ----------------
    int          low_cnt = 0, rise_cnt = 0, since_rise = 0, high_cnt = 0;
    int          frames_done = 0, err_cnt = 0;
    bit          prev_csn = 1'b1, prev_sclk = 1'b0, prev_sdi = 1'b0, prev_busy = 1'b0, have_prev = 1'b0;
    logic [31:0] sdi_word = '0;

    always @(negedge clk) begin
        if (rst) begin
            low_cnt = 0; rise_cnt = 0; since_rise = 0; high_cnt = 0;
            prev_csn = 1'b1; prev_sclk = 1'b0; prev_sdi = 1'b0; prev_busy = 1'b0; have_prev = 1'b0;
        end else begin
            if (!csn && prev_csn) begin
                if (have_prev) check("cs_gap", high_cnt >= GAPC, high_cnt, GAPC);
                low_cnt = 0; rise_cnt = 0; since_rise = 0; sdi_word = '0;
            end
            if (csn) high_cnt = prev_csn ? high_cnt + 1 : 1;
            if (!csn) begin
                low_cnt++;
                if (sclk && !prev_sclk) begin
                    check("sdi_stable", sdi == prev_sdi, sdi, prev_sdi);
                    if (rise_cnt > 0) check("sclk_period", since_rise == 2 * DIV, since_rise, 2 * DIV);
                    since_rise = 0;
                    rise_cnt++;
                    sdi_word = {sdi_word[30:0], sdi};
                end
                since_rise++;
            end
            if (csn && !prev_csn) begin
                check("csn_low_len", low_cnt == 2 * DIV * (FB + 1), low_cnt, 2 * DIV * (FB + 1));
                check("sclk_rises", rise_cnt == FB, rise_cnt, FB);
                if (exp_cmd.size() == 0) check("unexpected_frame", 1'b0, sdi_word, 0);
                else begin
                    logic [31:0] e;
                    e = exp_cmd.pop_front();
                    check("cmd_word", sdi_word == e, sdi_word, e);
                end
                frames_done++;
                have_prev = 1'b1;
            end
            if (data_valid) begin
                check("dv_first_gap_cycle", csn && !prev_csn, {csn, prev_csn}, 2'b10);
                if (exp_res.size() == 0) check("unexpected_valid", 1'b0, data_o, 0);
                else begin
                    res_t r;
                    r = exp_res.pop_front();
                    check("data_o", data_o == r.dat, data_o, r.dat);
                    check("ch_o", ch_o == r.ch, ch_o, r.ch);
                end
            end
            if (!busy && prev_busy) check("busy_fall_time", high_cnt == GAPC + 1, high_cnt, GAPC + 1);
            if (err) err_cnt++;
            prev_csn = csn; prev_sclk = sclk; prev_sdi = sdi; prev_busy = busy;
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start(input logic m, input logic [1:0] ch, input logic [3:0] mask, input logic exp_busy);
        @(negedge clk);
        mode = m; ch_sel = ch; ch_mask = mask; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy == exp_busy, busy, exp_busy);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", !busy, n, 3000);
        check("res_drained", exp_res.size() == 0, exp_res.size(), 0);
        check("cmd_drained", exp_cmd.size() == 0, exp_cmd.size(), 0);
    endtask

    task automatic do_single(input logic [1:0] ch);
        exp_cmd.push_back(cmd_of(ch));
        exp_cmd.push_back(32'h0);
        exp_res.push_back('{ch: ch, dat: ain[ch]});
        pulse_start(1'b0, ch, 4'($urandom), 1'b1);
        ch_sel = ~ch;  // must be ignored while busy
        wait_idle();
    endtask

    task automatic do_cont(input logic [3:0] mask, input int nfr);
        int lst[$];
        int base, n;
        for (int i = 0; i < NUM_CH; i++) if (mask[i]) lst.push_back(i);
        for (int k = 0; k < nfr; k++) begin
            logic [1:0] c;
            c = 2'(lst[k % lst.size()]);
            exp_cmd.push_back(cmd_of(c));
            exp_res.push_back('{ch: c, dat: ain[c]});
        end
        exp_cmd.push_back(32'h0);
        base = frames_done;
        run  = 1'b1;
        pulse_start(1'b1, 2'($urandom), mask, 1'b1);
        ch_mask = 4'($urandom);  // must be ignored while busy
        n = 0;
        while (frames_done < base + nfr && n < 200 * nfr + 500) begin
            @(negedge clk);
            n++;
        end
        check("frame_wait_timeout", frames_done >= base + nfr, frames_done - base, nfr);
        run = 1'b0;
        wait_idle();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; run = 1'b0; ch_sel = '0; ch_mask = '0;
        for (int i = 0; i < NUM_CH; i++) ain[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_csn", csn == 1'b1, csn, 1);
        check("rst_sclk", sclk == 1'b0, sclk, 0);
        check("rst_sdi", sdi == 1'b0, sdi, 0);
        check("rst_busy", busy == 1'b0, busy, 0);
        check("rst_dv", data_valid == 1'b0, data_valid, 0);
        check("rst_err", err == 1'b0, err, 0);
        check("rst_data", data_o == 16'h0, data_o, 0);
        check("rst_ch", ch_o == 2'd0, ch_o, 0);
        rst = 1'b0;
        @(negedge clk);

        ain[0] = 16'hCAFE; do_single(2'd0);
        ain[3] = 16'h8001; do_single(2'd3);
        ain[0] = 16'h1234; ain[2] = 16'hBEEF; do_cont(4'b0101, 5);
        ain[3] = 16'($urandom); do_cont(4'b1000, 3);

        // empty-mask continuous start is rejected
        begin
            int  e0;
            bit  busy_seen, csn_low_seen;
            e0 = err_cnt; busy_seen = 1'b0; csn_low_seen = 1'b0;
            pulse_start(1'b1, 2'd0, 4'b0000, 1'b0);
            repeat (10) begin
                @(negedge clk);
                busy_seen    |= busy;
                csn_low_seen |= !csn;
            end
            check("err_pulses", err_cnt - e0 == 1, err_cnt - e0, 1);
            check("err_busy_low", !busy_seen, busy_seen, 0);
            check("err_csn_high", !csn_low_seen, csn_low_seen, 0);
        end

        // reset in the middle of the first frame
        begin
            int n;
            pulse_start(1'b0, 2'd2, 4'b0000, 1'b1);
            n = 0;
            while (rise_cnt < 10 && n < 500) begin
                @(negedge clk);
                n++;
            end
            check("abort_wait_timeout", rise_cnt >= 10, rise_cnt, 10);
            rst = 1'b1;
            #1;
            check("abort_csn", csn == 1'b1, csn, 1);
            check("abort_sclk", sclk == 1'b0, sclk, 0);
            check("abort_busy", busy == 1'b0, busy, 0);
            repeat (2) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            ain[2] = 16'($urandom);
            do_single(2'd2);
        end

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NUM_CH; i++) ain[i] = 16'($urandom);
            if ($urandom_range(0, 1) == 0) do_single(2'($urandom));
            else do_cont(4'($urandom_range(1, 15)), $urandom_range(2, 6));
        end

        check("err_total", err_cnt == 1, err_cnt, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #700000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/ads_spi_seq_ctrl.md
Name: ads_spi_seq_ctrl

Overview:
Synthesisable SPI master sequencer for ADS868x-family multichannel SAR ADCs. It generalises the single-frame ADS8684 exchange to NUM_CH channels with configurable frame width and SCLK rate. It runs two modes: single-shot conversion and continuous round-robin over a channel mask. It sits between the ADC pins and the acquisition/buffer logic, and emits tagged samples with a one-cycle valid strobe.

Parameters:
NUM_CH, 4, number of ADC channels (2..8)
DATA_WIDTH, 16, result bits taken MSB-first from the start of each frame
FRAME_BITS, 32, SCLK periods per frame (>= DATA_WIDTH, >= 16)
SCLK_DIV, 2, SCLK half-period in clk cycles (>= 1)
CS_GAP, 4, minimum clk cycles csn stays high between frames (>= 1)
CMD_BASE, 16'hC000, manual-channel command base
CH_SHIFT, 10, left shift applied to the channel index in the command

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin operation; sampled only in IDLE
mode  in  1  0 = single-shot, 1 = continuous
ch_sel  in  $clog2(NUM_CH)  channel for single-shot
ch_mask  in  NUM_CH  enabled channels for continuous; latched at start
run  in  1  continuous keep-going level; deassert to stop
busy  out  1  high from start acceptance until the final frame ends
data_o  out  DATA_WIDTH  captured result
ch_o  out  $clog2(NUM_CH)  channel tag for data_o
data_valid  out  1  one-cycle strobe; data_o and ch_o are valid while it is high
err  out  1  one-cycle strobe: start rejected (continuous with ch_mask==0)
csn  out  1  ADC chip select, active low
sclk  out  1  SPI clock, idle low
sdi  out  1  MOSI
sdo  in  1  MISO

Behaviour:
- Reset values: csn=1, sclk=0, sdi=0, busy=0, data_valid=0, err=0, data_o=0, ch_o=0, FSM=IDLE. Reset mid-frame aborts the frame immediately; no data_valid is issued for the aborted frame.
- Command word: {CMD_BASE | (ch<<CH_SHIFT)} in the upper 16 bits, zero-padded to FRAME_BITS. NO_OP is all zeros.
- Pipeline: the ADC returns the result of the command from the previous frame. Each result is captured in the frame after its command.
- FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> (SETUP | IDLE).
- IDLE: on start=1, latch mode, ch_sel and ch_mask; assert busy next cycle; go to SETUP.
- Continuous start with ch_mask==0: pulse err, stay IDLE, busy stays 0.
- SETUP: csn=0 for SCLK_DIV cycles. sdi holds the command MSB.
- SHIFT: FRAME_BITS periods, each SCLK_DIV cycles low then SCLK_DIV cycles high.
  - sdi changes only at the start of the low half.
  - sdo is sampled on the clk cycle sclk goes 0->1.
  - The first DATA_WIDTH sampled bits form the result, MSB first.
- HOLD: sclk=0 for SCLK_DIV cycles, then csn=1. Frame length with csn low is 2*SCLK_DIV*(FRAME_BITS+1) cycles.
- GAP: csn=1 for CS_GAP cycles. data_valid pulses in the first GAP cycle whenever the frame just ended carried a result.
- Single-shot: frame 1 sends the ch_sel command and produces no data_valid. Frame 2 sends NO_OP; data_valid fires with ch_o=ch_sel. busy drops on the cycle after that GAP completes.
- Continuous:
  - Channel order is ascending index over enabled bits, wrapping from the highest to the lowest.
  - Frame k sends the command for channel c_k and captures the result for c_{k-1}.
  - The first frame produces no data_valid.
  - run is sampled at the end of each GAP. If run=0, send one NO_OP flush frame, which yields the last result, then go to IDLE.
  - Single-bit masks repeat the same channel every frame.
- start while busy is ignored. ch_sel and ch_mask changes while busy are ignored until the next start.
- ch_sel >= NUM_CH is masked to its low bits; no error is raised.

Test Plan:
- Single-shot ch0, model ain_0p=16'hCAFE -> frame 1 sdi word 32'hC0000000, frame 2 sdi word 0; one data_valid with data_o=16'hCAFE, ch_o=0; busy then falls.
- Single-shot ch3, ain_3p=16'h8001 -> command 32'hCC000000; data_o=16'h8001, ch_o=3.
- Continuous, mask 4'b0101, ain0=16'h1234, ain2=16'hBEEF; run held for 5 frames, then dropped -> commands C000, C800, C000, C800, C000, then a NO_OP flush; data_valid sequence (0,1234), (2,BEEF), (0,1234), (2,BEEF), (0,1234).
- Timing with SCLK_DIV=2, FRAME_BITS=32, CS_GAP=4 -> csn low exactly 132 clk per frame; high >= 4 clk between frames; sclk period 4 clk; sdi stable across every sclk rising edge.
- Continuous start with ch_mask=0 -> err high exactly 1 cycle; busy stays 0; csn stays 1.
- Reset asserted at bit 10 of frame 1 -> csn=1 and sclk=0 immediately; no data_valid. A new single-shot afterwards returns the correct value.
